alu_arbiter: RTL and testbench

Shares the single 8-bit ALU datapath between two requesters using valid/ready handshakes and round-robin arbitration. Each request is captured into operand registers and executed on an embedded ALU instance. The result is registered and returned on one shared response channel, tagged with the requester id. The block sits between the two issuing engines and the ALU, and it contains the only ALU instance in the subsystem.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_arbiter_alu.sv | 49 ++++
 rtl/alu_arbiter.sv | 151 +++++++++++++++
 tb/tb_alu_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU arbiter slice:
//   DATA_W   - operand / result width of the ALU datapath
//   OP_*     - the 16 ALU_Sel opcode encodings
//   state_t  - arbiter FSM states
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W = 8;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_SHL  = 4'b0100;
    localparam logic [3:0] OP_SHR  = 4'b0101;
    localparam logic [3:0] OP_ROL  = 4'b0110;
    localparam logic [3:0] OP_ROR  = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1011;
    localparam logic [3:0] OP_NAND = 4'b1100;
    localparam logic [3:0] OP_XNOR = 4'b1101;
    localparam logic [3:0] OP_GT   = 4'b1110;
    localparam logic [3:0] OP_EQ   = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// ---------------------------------------------------------------------------
// alu_arbiter_alu
// Purely combinational 8-bit ALU datapath selected by a 4-bit ALU_Sel code.
// Ports:
//   a, b       in  DATA_W  operands
//   alu_sel    in  4       opcode (OP_* in alu_pkg)
//   alu_out    out DATA_W  result, truncated to DATA_W bits
//   carry_out  out 1       bit DATA_W of the zero-extended sum a+b
// Division by zero is not special-cased here; the caller owns that policy.
// ---------------------------------------------------------------------------
module alu_arbiter_alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        alu_sel,
    output logic [DATA_W-1:0] alu_out,
    output logic              carry_out
);

    logic [DATA_W:0] sum_ext;

    assign sum_ext   = {1'b0, a} + {1'b0, b};
    assign carry_out = sum_ext[DATA_W];

    always_comb begin
        alu_out = '0;
        case (alu_sel)
            OP_ADD:  alu_out = a + b;
            OP_SUB:  alu_out = a - b;
            OP_MUL:  alu_out = a * b;
            OP_DIV:  alu_out = a / b;
            OP_SHL:  alu_out = a << 1;
            OP_SHR:  alu_out = a >> 1;
            OP_ROL:  alu_out = {a[DATA_W-2:0], a[DATA_W-1]};
            OP_ROR:  alu_out = {a[0], a[DATA_W-1:1]};
            OP_AND:  alu_out = a & b;
            OP_OR:   alu_out = a | b;
            OP_XOR:  alu_out = a ^ b;
            OP_NOR:  alu_out = ~(a | b);
            OP_NAND: alu_out = ~(a & b);
            OP_XNOR: alu_out = ~(a ^ b);
            OP_GT:   alu_out = {{(DATA_W-1){1'b0}}, (a > b)};
            OP_EQ:   alu_out = {{(DATA_W-1){1'b0}}, (a == b)};
            default: alu_out = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one ALU between two requesters. A request is accepted in IDLE,
// its operands are registered, the ALU result is registered in EXEC and
// presented in RESP until the consumer takes it.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   reqN_valid/_ready         request handshake for requester N (0/1)
//   reqN_op/_a/_b             request opcode and operands
//   rsp_valid/_ready          response handshake
//   rsp_id                    requester that issued the operation
//   rsp_data/_carry/_err      result, ADD carry, divide-by-zero flag
//   busy                      high whenever the FSM is not in IDLE
//   ops_done                  saturating count of completed responses
// ---------------------------------------------------------------------------
module alu_arbiter
    import alu_pkg::*;
#(
    parameter bit                RR_EN       = 1'b1,
    parameter logic [DATA_W-1:0] DIV0_RESULT = 8'hFF,
    parameter int                CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [3:0]        req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [3:0]        req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_carry,
    output logic              rsp_err,
    output logic              busy,
    output logic [CNT_W-1:0]  ops_done
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t            state;
    logic              last_grant;
    logic              id_p0;
    logic [3:0]        op_p0;
    logic [DATA_W-1:0] a_p0;
    logic [DATA_W-1:0] b_p0;

    logic              grant_vld;
    logic              grant_id;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              div0;

    // Grant only exists in IDLE; on a tie the requester not served last wins
    // (round-robin) or requester 0 wins (fixed priority).
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (state == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = RR_EN ? ~last_grant : 1'b0;
            end else if (req0_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b0;
            end else if (req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    assign req0_ready = grant_vld & ~grant_id;
    assign req1_ready = grant_vld &  grant_id;

    // Stage p0: operand capture on accept
    always_ff @(posedge clk) begin
        if (grant_vld) begin
            op_p0 <= grant_id ? req1_op : req0_op;
            a_p0  <= grant_id ? req1_a  : req0_a;
            b_p0  <= grant_id ? req1_b  : req0_b;
        end
    end

    alu_arbiter_alu u_alu (
        .a         (a_p0),
        .b         (b_p0),
        .alu_sel   (op_p0),
        .alu_out   (alu_result),
        .carry_out (alu_carry)
    );

    assign div0 = (op_p0 == OP_DIV) && (b_p0 == '0);

    // Stage p1: control FSM and registered response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            id_p0      <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_carry  <= 1'b0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
            ops_done   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        state      <= EXEC;
                        busy       <= 1'b1;
                        id_p0      <= grant_id;
                        last_grant <= grant_id;
                    end
                end
                EXEC: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_id    <= id_p0;
                    rsp_data  <= div0 ? DIV0_RESULT : alu_result;
                    rsp_carry <= (op_p0 == OP_ADD) ? alu_carry : 1'b0;
                    rsp_err   <= div0;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        rsp_valid <= 1'b0;
                        ops_done  <= sat_inc(ops_done);
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
// Directed bench for alu_arbiter. Instance dut is round-robin with a 4-bit
// counter (so saturation is reachable); instance dut_fp is fixed priority
// with the default counter width and shares payload, rsp_ready and reset.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       fp_req0_valid = 1'b0, fp_req1_valid = 1'b0;
    logic [3:0] req0_op = '0, req1_op = '0;
    logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic       rsp_ready = 1'b1;

    logic       req0_ready, req1_ready, rsp_valid, rsp_id, rsp_carry, rsp_err, busy;
    logic [7:0] rsp_data;
    logic [3:0] ops_done;

    logic        fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_id;
    logic        fp_rsp_carry, fp_rsp_err, fp_busy;
    logic [7:0]  fp_rsp_data;
    logic [15:0] fp_ops_done;

    int n_tests = 0;
    int n_fail  = 0;

    logic       g_id, g_carry, g_err;
    logic [7:0] g_data;

    always #5 clk = ~clk;

    alu_arbiter #(.RR_EN(1'b1), .DIV0_RESULT(8'hFF), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
        .busy(busy), .ops_done(ops_done)
    );

    alu_arbiter #(.RR_EN(1'b0), .DIV0_RESULT(8'hFF), .CNT_W(16)) dut_fp (
        .clk(clk), .rst(rst),
        .req0_valid(fp_req0_valid), .req0_ready(fp_req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(fp_req1_valid), .req1_ready(fp_req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id),
        .rsp_data(fp_rsp_data), .rsp_carry(fp_rsp_carry), .rsp_err(fp_rsp_err),
        .busy(fp_busy), .ops_done(fp_ops_done)
    );

    // Drives one request on the chosen requester, waits (bounded) for accept
    // and response, leaves the response in g_* and lets the handshake finish.
    task automatic issue(input logic id, input logic [3:0] op,
                         input logic [7:0] a, input logic [7:0] b);
        int k;
        @(negedge clk);
        rsp_ready = 1'b1;
        req0_op = op; req0_a = a; req0_b = b;
        req1_op = op; req1_a = a; req1_b = b;
        req0_valid = ~id; req1_valid = id;
        #1;
        k = 0;
        while (((id ? req1_ready : req0_ready) !== 1'b1) && k < 20) begin
            @(negedge clk); #1; k++;
        end
        n_tests++;
        if (k >= 20) begin
            n_fail++;
            $display("FAIL issue_accept: ready stayed low, required 1 for id %0d", id);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        k = 0;
        @(negedge clk);
        while (rsp_valid !== 1'b1 && k < 20) begin
            @(negedge clk); k++;
        end
        n_tests++;
        if (k >= 20) begin
            n_fail++;
            $display("FAIL issue_response: rsp_valid stayed low, required 1");
        end
        g_id = rsp_id; g_data = rsp_data; g_carry = rsp_carry; g_err = rsp_err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        n_tests++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_err, busy, ops_done, fp_ops_done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b id=%b data=%h carry=%b err=%b busy=%b ops=%0d fp_ops=%0d, required all 0",
                     rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_err, busy, ops_done, fp_ops_done);
        end
        rst = 1'b0;
    endtask

    task automatic test_add_latency();
        @(negedge clk);
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 8'd200; req0_b = 8'd100;
        #1;
        n_tests++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL add_accept: ready0/1=%b%b, required 10", req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({busy, rsp_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL add_cycle1: busy=%b rsp_valid=%b, required busy=1 rsp_valid=0", busy, rsp_valid);
        end
        @(negedge clk);
        n_tests++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_err} !== {1'b1, 1'b0, 8'd44, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL add_cycle2: valid=%b id=%b data=%0d carry=%b err=%b, required 1 0 44 1 0",
                     rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_err);
        end
        @(negedge clk);
        n_tests++;
        if ({rsp_valid, busy, ops_done} !== {1'b0, 1'b0, 4'd1}) begin
            n_fail++;
            $display("FAIL add_done: valid=%b busy=%b ops_done=%0d, required 0 0 1", rsp_valid, busy, ops_done);
        end
    endtask

    task automatic test_div();
        issue(1'b1, OP_DIV, 8'd10, 8'd0);
        n_tests++;
        if ({g_id, g_data, g_err, g_carry} !== {1'b1, 8'hFF, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL div_by_zero: id=%b data=%h err=%b carry=%b, required 1 ff 1 0", g_id, g_data, g_err, g_carry);
        end
        issue(1'b1, OP_DIV, 8'd200, 8'd7);
        n_tests++;
        if ({g_id, g_data, g_err, g_carry} !== {1'b1, 8'd28, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL div_normal: id=%b data=%0d err=%b carry=%b, required 1 28 0 0", g_id, g_data, g_err, g_carry);
        end
        n_tests++;
        if (ops_done !== 4'd3) begin
            n_fail++;
            $display("FAIL div_count: ops_done=%0d, required 3", ops_done);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = OP_SUB; req0_a = 8'd5; req0_b = 8'd7;
        #1;
        n_tests++;
        if (req0_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_accept: req0_ready=%b, required 1", req0_ready);
        end
        @(posedge clk); #1;
        req0_op = OP_ADD; req0_a = 8'd2; req0_b = 8'd2;
        req1_valid = 1'b1; req1_op = OP_ADD; req1_a = 8'd1; req1_b = 8'd1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if ({rsp_valid, rsp_id, rsp_data, rsp_carry, req0_ready, req1_ready, busy} !==
                {1'b1, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: valid=%b id=%b data=%h carry=%b rdy=%b%b busy=%b, required 1 0 fe 0 00 1",
                         i, rsp_valid, rsp_id, rsp_data, rsp_carry, req0_ready, req1_ready, busy);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        n_tests++;
        if ({rsp_valid, req0_ready, req1_ready, ops_done} !== {1'b0, 1'b0, 1'b1, 4'd4}) begin
            n_fail++;
            $display("FAIL bp_release: valid=%b rdy=%b%b ops_done=%0d, required 0 01 4",
                     rsp_valid, req0_ready, req1_ready, ops_done);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_contention();
        int n0, n1, f0, f1, kr, kf;
        logic e_id;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        rsp_ready = 1'b1;
        req0_op = OP_ADD; req0_a = 8'd3;  req0_b = 8'd4;
        req1_op = OP_ADD; req1_a = 8'd10; req1_b = 8'd20;
        n0 = 4; n1 = 4; f0 = 4; f1 = 4; kr = 0; kf = 0;
        for (int cyc = 0; cyc < 100 && (kr < 8 || kf < 8); cyc++) begin
            @(negedge clk);
            req0_valid = (n0 > 0); req1_valid = (n1 > 0);
            fp_req0_valid = (f0 > 0); fp_req1_valid = (f1 > 0);
            #1;
            if (req0_ready) n0--;
            if (req1_ready) n1--;
            if (fp_req0_ready) f0--;
            if (fp_req1_ready) f1--;
            if (rsp_valid) begin
                e_id = kr[0];
                n_tests++;
                if ({rsp_id, rsp_data} !== {e_id, (e_id ? 8'd30 : 8'd7)}) begin
                    n_fail++;
                    $display("FAIL rr_order%0d: id=%b data=%0d, required id=%b data=%0d",
                             kr, rsp_id, rsp_data, e_id, e_id ? 30 : 7);
                end
                kr++;
            end
            if (fp_rsp_valid) begin
                e_id = (kf >= 4);
                n_tests++;
                if ({fp_rsp_id, fp_rsp_data} !== {e_id, (e_id ? 8'd30 : 8'd7)}) begin
                    n_fail++;
                    $display("FAIL fp_order%0d: id=%b data=%0d, required id=%b data=%0d",
                             kf, fp_rsp_id, fp_rsp_data, e_id, e_id ? 30 : 7);
                end
                kf++;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0; fp_req0_valid = 1'b0; fp_req1_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (kr != 8 || kf != 8 || ops_done !== 4'd8 || fp_ops_done !== 16'd8) begin
            n_fail++;
            $display("FAIL contention_count: rr=%0d fp=%0d ops=%0d fp_ops=%0d, required 8 8 8 8",
                     kr, kf, ops_done, fp_ops_done);
        end
    endtask

    task automatic test_reset_exec();
        @(negedge clk);
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 8'd1; req0_b = 8'd1;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_exec_busy: busy=%b, required 1", busy);
        end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({busy, rsp_valid, ops_done} !== '0) begin
            n_fail++;
            $display("FAIL rst_async: busy=%b rsp_valid=%b ops_done=%0d, required 0 0 0", busy, rsp_valid, ops_done);
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_first_tie: rdy=%b%b, required 10", req0_ready, req1_ready);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if ({rsp_valid, busy} !== 2'b00) begin
                n_fail++;
                $display("FAIL rst_dropped%0d: rsp_valid=%b busy=%b, required 0 0", i, rsp_valid, busy);
            end
        end
    endtask

    task automatic test_saturation();
        logic [3:0] t_op [13] = '{OP_ADD, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SHL, OP_SHR,
                                  OP_ROR, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_NAND};
        logic [7:0] t_a  [13] = '{8'd200, 8'd1, 8'd5, 8'd20, 8'd200, 8'h81, 8'h81,
                                  8'h81, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0};
        logic [7:0] t_b  [13] = '{8'd100, 8'd2, 8'd7, 8'd20, 8'd7, 8'h00, 8'h00,
                                  8'h00, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C};
        logic [7:0] t_r  [13] = '{8'd44, 8'd3, 8'hFE, 8'h90, 8'd28, 8'h02, 8'h40,
                                  8'hC0, 8'h30, 8'hFC, 8'hCC, 8'h03, 8'hCF};
        for (int i = 0; i < 13; i++) begin
            issue(1'b0, t_op[i], t_a[i], t_b[i]);
            n_tests++;
            if ({g_data, g_carry, g_err} !== {t_r[i], (i == 0), 1'b0}) begin
                n_fail++;
                $display("FAIL vec%0d: data=%h carry=%b err=%b, required %h %b 0",
                         i, g_data, g_carry, g_err, t_r[i], (i == 0));
            end
        end
        issue(1'b0, OP_ROL, 8'h81, 8'h00);
        n_tests++;
        if ({g_data, ops_done} !== {8'h03, 4'd14}) begin
            n_fail++;
            $display("FAIL sat_rol: data=%h ops_done=%0d, required 03 14", g_data, ops_done);
        end
        issue(1'b1, OP_GT, 8'd9, 8'd3);
        n_tests++;
        if ({g_data, ops_done} !== {8'd1, 4'd15}) begin
            n_fail++;
            $display("FAIL sat_full: data=%0d ops_done=%0d, required 1 15", g_data, ops_done);
        end
        issue(1'b1, OP_EQ, 8'd5, 8'd6);
        n_tests++;
        if ({g_data, ops_done} !== {8'd0, 4'd15}) begin
            n_fail++;
            $display("FAIL sat_hold: data=%0d ops_done=%0d, required 0 15", g_data, ops_done);
        end
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_div();
        test_backpressure();
        test_contention();
        test_reset_exec();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
